// File: rtl/min_run_length_encoder.sv
// Run-length encoder for the running-minimum sample stream: folds equal samples
// into {value, length} records and queues them in a small FIFO for the print stage.
module min_run_length_encoder #(
  parameter int DW    = 2,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_val,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [DW-1:0]    out_val,
  output logic [CNT_W-1:0] out_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             run_open
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CNT_W-1:0] MAX_LEN  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LEN_ONE  = CNT_W'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [DW-1:0]     cur_val_q;
  logic [CNT_W-1:0]  cur_len_q;
  logic              run_open_q;

  logic [DW-1:0]     mem_val_q [DEPTH];
  logic [CNT_W-1:0]  mem_len_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              sample_acc;
  logic              flush_acc;
  logic              push;
  logic              pop;

  // Handshake decode; in_ready/out_valid come straight from registered flags.
  assign sample_acc = in_valid & in_ready_q & ~flush;
  assign flush_acc  = flush & in_ready_q;
  assign pop        = out_valid_q & out_ready;

  // A record is closed by a value change, a saturated run, or a flush of an open run.
  always_comb begin
    push = 1'b0;
    case (state_q)
      S_RUN: begin
        if (flush_acc) begin
          push = 1'b1;
        end else if (sample_acc) begin
          if ((in_val != cur_val_q) || (cur_len_q == MAX_LEN)) begin
            push = 1'b1;
          end else begin
            push = 1'b0;
          end
        end else begin
          push = 1'b0;
        end
      end
      S_IDLE:  push = 1'b0;
      default: push = 1'b0;
    endcase
  end

  // Run accumulator FSM; a saturated run restarts at length 1 instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_val_q  <= {DW{1'b0}};
      cur_len_q  <= {CNT_W{1'b0}};
      run_open_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sample_acc) begin
            state_q    <= S_RUN;
            cur_val_q  <= in_val;
            cur_len_q  <= LEN_ONE;
            run_open_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (flush_acc) begin
            state_q    <= S_IDLE;
            cur_val_q  <= {DW{1'b0}};
            cur_len_q  <= {CNT_W{1'b0}};
            run_open_q <= 1'b0;
          end else if (sample_acc) begin
            if ((in_val == cur_val_q) && (cur_len_q != MAX_LEN)) begin
              cur_len_q <= cur_len_q + LEN_ONE;
            end else begin
              cur_val_q <= in_val;
              cur_len_q <= LEN_ONE;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          cur_val_q  <= {DW{1'b0}};
          cur_len_q  <= {CNT_W{1'b0}};
          run_open_q <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy next-state; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Record FIFO storage, wrapping pointers and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_val_q[i] <= {DW{1'b0}};
        mem_len_q[i] <= {CNT_W{1'b0}};
      end
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= CNT_ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem_val_q[wr_ptr_q] <= cur_val_q;
        mem_len_q[wr_ptr_q] <= cur_len_q;
        wr_ptr_q            <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q     <= count_d;
      in_ready_q  <= (count_d != CNT_FULL);
      out_valid_q <= (count_d != CNT_ZERO);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_val   = mem_val_q[rd_ptr_q];
  assign out_len   = mem_len_q[rd_ptr_q];
  assign run_open  = run_open_q;

endmodule

// File: tb/tb_min_run_length_encoder.sv
// Directed bench for min_run_length_encoder: a vector table for the basic stream
// plus hand-written sequences for back-pressure, run splitting and reset.
module tb_min_run_length_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_val;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [1:0] out_val;
  logic [7:0] out_len;
  logic       out_valid;
  logic       out_ready;
  logic       run_open;

  logic [1:0] b_in_val;
  logic       b_in_valid;
  logic       b_in_ready;
  logic       b_flush;
  logic [1:0] b_out_val;
  logic [1:0] b_out_len;
  logic       b_out_valid;
  logic       b_out_ready;
  logic       b_run_open;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] v;
    logic [7:0] l;
  } rec_t;

  typedef struct {
    logic       in_valid;
    logic [1:0] in_val;
    logic       flush;
    logic       out_ready;
    logic       e_ov;
    logic [1:0] e_val;
    logic [7:0] e_len;
    logic       e_ir;
    logic       e_ro;
  } vec_t;

  rec_t got_a[$];
  rec_t exp_a[$];
  rec_t got_b[$];
  vec_t tbl[14];

  always #5 clk = ~clk;

  min_run_length_encoder dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_val(out_val), .out_len(out_len), .out_valid(out_valid),
    .out_ready(out_ready), .run_open(run_open)
  );

  min_run_length_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_val(b_in_val), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .flush(b_flush), .out_val(b_out_val), .out_len(b_out_len), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .run_open(b_run_open)
  );

  // Record every popped head (values seen just before the edge).
  always @(posedge clk) begin
    if (rst && out_valid && out_ready) got_a.push_back('{v: out_val, l: out_len});
    if (rst && b_out_valid && b_out_ready) got_b.push_back('{v: b_out_val, l: {6'd0, b_out_len}});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] val, input logic f, input logic ordy);
    @(negedge clk);
    in_valid = v; in_val = val; flush = f; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [1:0] val, input logic f);
    @(negedge clk);
    b_in_valid = v; b_in_val = val; b_flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid) break;
    end
    chk("drain_done", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic cmp_recs(input string name);
    chk({name, "_count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      chk($sformatf("%s_rec%0d", name, i), {22'd0, got_a[i]}, {22'd0, exp_a[i]});
    end
  endtask

  initial begin
    rst = 1'b0;
    in_val = 2'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    b_in_val = 2'd0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;

    //               v     val   fl    ordy  ov    val   len   ir    ro
    tbl[0]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 8'd3, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 2'd0, 8'd1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd3, 8'd1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd2, 8'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'd3, 8'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0};

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_val", {30'd0, out_val}, 32'd0);
    chk("rst_out_len", {24'd0, out_len}, 32'd0);
    chk("rst_run_open", {31'd0, run_open}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Basic stream, flush in IDLE and dropped sample during flush.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].in_valid, tbl[i].in_val, tbl[i].flush, tbl[i].out_ready);
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
      chk($sformatf("tbl%0d_run_open", i), {31'd0, run_open}, {31'd0, tbl[i].e_ro});
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_out_val", i), {30'd0, out_val}, {30'd0, tbl[i].e_val});
        chk($sformatf("tbl%0d_out_len", i), {24'd0, out_len}, {24'd0, tbl[i].e_len});
      end
    end

    // Push and pop together at count 2, then fill to prove the count held.
    got_a.delete(); exp_a.delete();
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    chk("pp_head_val0", {30'd0, out_val}, 32'd0);
    step(1'b1, 2'd3, 1'b0, 1'b1);
    chk("pp_head_val1", {30'd0, out_val}, 32'd1);
    chk("pp_head_len1", {24'd0, out_len}, 32'd1);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    chk("pp_ready_cnt3", {31'd0, in_ready}, 32'd1);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    chk("pp_full_cnt4", {31'd0, in_ready}, 32'd0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("pp_flush_blocked", {31'd0, run_open}, 32'd1);
    drain();
    step(1'b0, 2'd0, 1'b1, 1'b1);
    drain();
    exp_a.push_back('{v: 2'd0, l: 8'd1}); exp_a.push_back('{v: 2'd1, l: 8'd1});
    exp_a.push_back('{v: 2'd2, l: 8'd1}); exp_a.push_back('{v: 2'd3, l: 8'd1});
    exp_a.push_back('{v: 2'd0, l: 8'd1}); exp_a.push_back('{v: 2'd1, l: 8'd1});
    cmp_recs("pp");

    // Back-pressure: fill with out_ready low, hold the blocked sample, then drain.
    got_a.delete(); exp_a.delete();
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    chk("bp_head_len", {24'd0, out_len}, 32'd1);
    step(1'b1, 2'd1, 1'b0, 1'b1);
    chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
    step(1'b1, 2'd1, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b1, 1'b1);
    chk("bp_run_closed", {31'd0, run_open}, 32'd0);
    drain();
    for (int i = 0; i < 6; i++) exp_a.push_back('{v: (i % 2 == 0) ? 2'd0 : 2'd1, l: 8'd1});
    cmp_recs("bp");

    // Saturating run split on the 2-bit length instance.
    for (int i = 0; i < 7; i++) step_b(1'b1, 2'd2, 1'b0);
    step_b(1'b0, 2'd0, 1'b1);
    step_b(1'b0, 2'd0, 1'b0);
    step_b(1'b0, 2'd0, 1'b0);
    chk("split_count", got_b.size(), 32'd3);
    chk("split_run_open", {31'd0, b_run_open}, 32'd0);
    if (got_b.size() == 3) begin
      chk("split_rec0", {22'd0, got_b[0]}, {22'd0, 2'd2, 8'd3});
      chk("split_rec1", {22'd0, got_b[1]}, {22'd0, 2'd2, 8'd3});
      chk("split_rec2", {22'd0, got_b[2]}, {22'd0, 2'd2, 8'd1});
    end
    foreach (got_b[i]) chk($sformatf("split_nonzero%0d", i), {31'd0, (got_b[i].l == 8'd0)}, 32'd0);

    // Asynchronous reset with two buffered records and an open run.
    got_a.delete(); exp_a.delete();
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_run_open", {31'd0, run_open}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    got_a.delete();
    step(1'b1, 2'd3, 1'b0, 1'b0);
    chk("post_rst_run_open", {31'd0, run_open}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("post_rst_head_val", {30'd0, out_val}, 32'd3);
    chk("post_rst_head_len", {24'd0, out_len}, 32'd1);
    drain();
    exp_a.push_back('{v: 2'd3, l: 8'd1});
    cmp_recs("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
